// File: rtl/mac_rx_fcs_check.sv
// rtl/mac_rx_fcs_check.sv - Ethernet RX FCS check, FCS strip and per-frame status
//
// Consumes the post-SFD byte stream (destination MAC through FCS), runs CRC-32
// over every byte, forwards all but the last four bytes, and reports one status
// pulse per frame (CRC verdict, length-range error, abort, length).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        qualifies in_data/in_sof/in_eof
//   in_data         frame byte
//   in_sof/in_eof   first byte / last FCS byte of frame
//   out_valid       qualifies out_data/out_sof/out_eof
//   out_data        forwarded byte (FCS never forwarded)
//   out_sof/out_eof first / last forwarded byte
//   stat_valid      one-cycle frame status pulse
//   stat_crc_ok     CRC residue matched
//   stat_len_err    length outside [MIN_FRAME, MAX_FRAME] (when CHECK_LEN)
//   stat_abort      frame cut short by a new in_sof
//   stat_frame_len  bytes accepted, FCS included, saturating at 2047
module mac_rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CHECK_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        stat_valid,
  output logic        stat_crc_ok,
  output logic        stat_len_err,
  output logic        stat_abort,
  output logic [10:0] stat_frame_len
);

  localparam logic [31:0] CRC_SEED = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;
  localparam logic [10:0] LEN_MAX  = 11'd2047;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [10:0] len;
  logic [31:0] dly;       // byte k-4 sits in [31:24] once four bytes are buffered
  logic        pend_one;  // 1-byte frame status deferred behind an abort status

  logic [31:0] crc_nxt;
  logic [10:0] len_inc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic len_bad(input logic [10:0] n);
    return (CHECK_LEN != 0) && ((int'(n) < MIN_FRAME) || (int'(n) > MAX_FRAME));
  endfunction

  // A sof byte always starts from a fresh seed, whether from IDLE or as an abort.
  always_comb begin
    crc_nxt = crc_byte(in_sof ? CRC_SEED : crc, in_data);
    len_inc = (len == LEN_MAX) ? LEN_MAX : len + 11'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      crc            <= CRC_SEED;
      len            <= '0;
      dly            <= '0;
      pend_one       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_sof        <= 1'b0;
      out_eof        <= 1'b0;
      stat_valid     <= 1'b0;
      stat_crc_ok    <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_abort     <= 1'b0;
      stat_frame_len <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      stat_valid <= 1'b0;
      stat_abort <= 1'b0;

      if (pend_one) begin
        pend_one       <= 1'b0;
        stat_valid     <= 1'b1;
        stat_crc_ok    <= 1'b0;
        stat_len_err   <= len_bad(11'd1);
        stat_frame_len <= 11'd1;
      end

      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_sof) begin
              crc <= crc_nxt;
              len <= 11'd1;
              dly <= {24'd0, in_data};
              if (in_eof) begin
                stat_valid     <= 1'b1;
                stat_crc_ok    <= 1'b0;
                stat_len_err   <= len_bad(11'd1);
                stat_frame_len <= 11'd1;
              end else begin
                state <= FRAME;
              end
            end
          end
          FRAME: begin
            if (in_sof) begin
              // Abort: report the old frame, flush the delay line, restart.
              stat_valid     <= 1'b1;
              stat_abort     <= 1'b1;
              stat_crc_ok    <= 1'b0;
              stat_len_err   <= len_bad(len);
              stat_frame_len <= len;
              crc            <= crc_nxt;
              len            <= 11'd1;
              dly            <= {24'd0, in_data};
              if (in_eof) begin
                pend_one <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              crc <= crc_nxt;
              len <= len_inc;
              dly <= {dly[23:0], in_data};
              if (len >= 11'd4) begin
                out_valid <= 1'b1;
                out_data  <= dly[31:24];
                out_sof   <= (len == 11'd4);
                out_eof   <= in_eof;
              end
              if (in_eof) begin
                stat_valid     <= 1'b1;
                stat_crc_ok    <= (crc_nxt == RESIDUE);
                stat_len_err   <= len_bad(len_inc);
                stat_frame_len <= len_inc;
                state          <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// tb/tb_mac_rx_fcs_check.sv - directed self-checking bench for mac_rx_fcs_check
module tb_mac_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sof, in_eof;
  logic [7:0]  in_data;

  logic        out_valid, out_sof, out_eof;
  logic [7:0]  out_data;
  logic        stat_valid, stat_crc_ok, stat_len_err, stat_abort;
  logic [10:0] stat_frame_len;

  logic        b_out_valid, b_out_sof, b_out_eof;
  logic [7:0]  b_out_data;
  logic        b_stat_valid, b_stat_crc_ok, b_stat_len_err, b_stat_abort;
  logic [10:0] b_stat_frame_len;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mac_rx_fcs_check #(.MIN_FRAME(64), .MAX_FRAME(1518), .CHECK_LEN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .stat_valid(stat_valid), .stat_crc_ok(stat_crc_ok), .stat_len_err(stat_len_err),
    .stat_abort(stat_abort), .stat_frame_len(stat_frame_len)
  );

  mac_rx_fcs_check #(.MIN_FRAME(64), .MAX_FRAME(1518), .CHECK_LEN(0)) dut_nolen (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sof(b_out_sof), .out_eof(b_out_eof),
    .stat_valid(b_stat_valid), .stat_crc_ok(b_stat_crc_ok), .stat_len_err(b_stat_len_err),
    .stat_abort(b_stat_abort), .stat_frame_len(b_stat_frame_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } ob_t;

  typedef struct {
    int          cyc;
    logic        crc_ok;
    logic        len_err;
    logic        abort;
    logic [10:0] len;
    logic        b_len_err;
  } st_t;

  typedef logic [7:0] bq_t[$];

  ob_t oq[$];
  st_t sq[$];

  always @(negedge clk) begin
    if (out_valid) oq.push_back('{out_data, out_sof, out_eof});
    if (stat_valid) sq.push_back('{cyc, stat_crc_ok, stat_len_err, stat_abort, stat_frame_len, b_stat_len_err});
  end

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  // payload byte i = base + i, followed by the FCS (complemented CRC, LSB first)
  task automatic make_frame(input int n_payload, input int base, output bq_t f);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    f = {};
    for (int i = 0; i < n_payload; i++) begin
      f.push_back(8'(base + i));
      c = ref_crc(c, 8'(base + i));
    end
    c = ~c;
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
    end
  endtask

  task automatic send(input bq_t f, input int n, input bit with_eof, input int gap, output int eof_cyc);
    eof_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (gap != 0 && (i % gap) == gap - 1) idle(1);
      drive(f[i], i == 0, with_eof && (i == n - 1));
      if (with_eof && i == n - 1) eof_cyc = cyc;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_sof, out_eof, out_data} !== 11'd0) begin
      failures++;
      $display("FAIL reset_out: got v=%b s=%b e=%b d=%h want all 0", out_valid, out_sof, out_eof, out_data);
    end
    checks++;
    if ({stat_valid, stat_crc_ok, stat_len_err, stat_abort, stat_frame_len} !== 15'd0) begin
      failures++;
      $display("FAIL reset_stat: got v=%b len=%0d want all 0", stat_valid, stat_frame_len);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good;
    bq_t f;
    int ec, bad;
    oq.delete(); sq.delete();
    make_frame(60, 0, f);
    send(f, 64, 1, 0, ec);
    idle(3);
    checks++;
    if (oq.size() !== 60) begin
      failures++;
      $display("FAIL good_outcount: got %0d want 60", oq.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 60; i++)
        if (oq[i].d !== 8'(i) || oq[i].sof !== (i == 0) || oq[i].eof !== (i == 59)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL good_stream: got %0d bad bytes want 0 (last d=%h eof=%b)", bad, oq[59].d, oq[59].eof);
      end
    end
    checks++;
    if (sq.size() !== 1) begin
      failures++;
      $display("FAIL good_statcount: got %0d want 1", sq.size());
    end else begin
      checks++;
      if (sq[0].cyc !== ec + 1) begin
        failures++;
        $display("FAIL good_statcyc: got %0d want %0d", sq[0].cyc, ec + 1);
      end
      checks++;
      if ({sq[0].crc_ok, sq[0].len_err, sq[0].abort, sq[0].len} !== {3'b100, 11'd64}) begin
        failures++;
        $display("FAIL good_stat: got crc=%b lerr=%b ab=%b len=%0d want 1 0 0 64",
                 sq[0].crc_ok, sq[0].len_err, sq[0].abort, sq[0].len);
      end
    end
  endtask

  task automatic test_bad_crc;
    bq_t f;
    int ec, bad;
    oq.delete(); sq.delete();
    make_frame(60, 0, f);
    f[10] = f[10] ^ 8'h01;
    send(f, 64, 1, 0, ec);
    idle(3);
    bad = 0;
    if (oq.size() != 60) bad = 100;
    else
      for (int i = 0; i < 60; i++)
        if (oq[i].d !== ((i == 10) ? 8'h0B : 8'(i))) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL badcrc_stream: got %0d bad (count %0d) want 0", bad, oq.size());
    end
    checks++;
    if (sq.size() != 1 || {sq[0].crc_ok, sq[0].len_err, sq[0].len} !== {2'b00, 11'd64}) begin
      failures++;
      $display("FAIL badcrc_stat: got n=%0d crc=%b lerr=%b want 1 stat crc=0 lerr=0 len=64",
               sq.size(), (sq.size() > 0) ? sq[0].crc_ok : 1'bx, (sq.size() > 0) ? sq[0].len_err : 1'bx);
    end
  endtask

  task automatic test_short;
    bq_t f;
    int ec;
    oq.delete(); sq.delete();
    make_frame(56, 3, f);
    send(f, 60, 1, 0, ec);
    idle(3);
    checks++;
    if (oq.size() !== 56 || oq[55].eof !== 1'b1 || oq[55].d !== 8'(3 + 55)) begin
      failures++;
      $display("FAIL short_out: got count %0d want 56 ending with eof", oq.size());
    end
    checks++;
    if (sq.size() != 1 || {sq[0].crc_ok, sq[0].len_err, sq[0].b_len_err, sq[0].len} !== {3'b110, 11'd60}) begin
      failures++;
      $display("FAIL short_stat: got n=%0d crc/lerr/lerr_nocheck/len=%b%b%b/%0d want 110/60",
               sq.size(), sq[0].crc_ok, sq[0].len_err, sq[0].b_len_err, sq[0].len);
    end
  endtask

  task automatic test_abort;
    bq_t f, g;
    int ec, ec2, bad;
    oq.delete(); sq.delete();
    make_frame(96, 0, f);
    make_frame(60, 8'h40, g);
    send(f, 30, 0, 3, ec);
    send(g, 64, 1, 0, ec2);
    idle(3);
    bad = 0;
    if (oq.size() != 86) bad = 1000;
    else begin
      for (int i = 0; i < 26; i++)
        if (oq[i].d !== 8'(i) || oq[i].eof !== 1'b0 || oq[i].sof !== (i == 0)) bad++;
      for (int i = 0; i < 60; i++)
        if (oq[26 + i].d !== 8'(8'h40 + i) || oq[26 + i].sof !== (i == 0) || oq[26 + i].eof !== (i == 59)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_stream: got %0d bad (count %0d) want 0 (count 86)", bad, oq.size());
    end
    checks++;
    if (sq.size() != 2) begin
      failures++;
      $display("FAIL abort_statcount: got %0d want 2", sq.size());
    end else begin
      checks++;
      if ({sq[0].abort, sq[0].crc_ok, sq[0].len} !== {2'b10, 11'd30}) begin
        failures++;
        $display("FAIL abort_stat: got ab=%b crc=%b len=%0d want 1 0 30", sq[0].abort, sq[0].crc_ok, sq[0].len);
      end
      checks++;
      if ({sq[1].abort, sq[1].crc_ok, sq[1].len_err, sq[1].len} !== {3'b010, 11'd64} || sq[1].cyc !== ec2 + 1) begin
        failures++;
        $display("FAIL abort_next: got ab=%b crc=%b lerr=%b len=%0d cyc=%0d want 0 1 0 64 cyc=%0d",
                 sq[1].abort, sq[1].crc_ok, sq[1].len_err, sq[1].len, sq[1].cyc, ec2 + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    bq_t f, g;
    int ec, ec2, bad;
    oq.delete(); sq.delete();
    make_frame(60, 8'h10, f);
    make_frame(60, 8'h80, g);
    send(f, 64, 1, 0, ec);
    send(g, 64, 1, 0, ec2);
    idle(3);
    bad = 0;
    if (oq.size() != 120) bad = 1000;
    else
      for (int i = 0; i < 120; i++)
        if (oq[i].d !== ((i < 60) ? 8'(8'h10 + i) : 8'(8'h80 + i - 60)) ||
            oq[i].sof !== (i == 0 || i == 60) || oq[i].eof !== (i == 59 || i == 119)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stream: got %0d bad (count %0d) want 0 (count 120)", bad, oq.size());
    end
    checks++;
    if (sq.size() != 2 || sq[1].cyc - sq[0].cyc != 64 || !sq[0].crc_ok || !sq[1].crc_ok) begin
      failures++;
      $display("FAIL b2b_stat: got n=%0d spacing=%0d want 2 pulses 64 apart both crc ok",
               sq.size(), (sq.size() == 2) ? sq[1].cyc - sq[0].cyc : -1);
    end
  endtask

  task automatic test_long;
    bq_t f;
    int ec;
    oq.delete(); sq.delete();
    make_frame(2096, 0, f);
    send(f, 2100, 1, 0, ec);
    idle(3);
    checks++;
    if (oq.size() !== 2096 || oq[2095].eof !== 1'b1) begin
      failures++;
      $display("FAIL long_out: got count %0d want 2096 ending with eof", oq.size());
    end
    checks++;
    if (sq.size() != 1 || {sq[0].crc_ok, sq[0].len_err, sq[0].len} !== {2'b11, 11'd2047}) begin
      failures++;
      $display("FAIL long_stat: got n=%0d crc=%b lerr=%b len=%0d want 1 1 1 2047",
               sq.size(), sq[0].crc_ok, sq[0].len_err, sq[0].len);
    end
  endtask

  task automatic test_reset_mid;
    bq_t f, g;
    int ec, neof;
    oq.delete(); sq.delete();
    make_frame(60, 8'h20, f);
    send(f, 20, 0, 0, ec);
    #2;
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sof, out_eof, stat_valid} !== 12'd0) begin
      failures++;
      $display("FAIL rstmid_imm: got v=%b d=%h stat=%b want all 0", out_valid, out_data, stat_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    neof = 0;
    foreach (oq[i]) if (oq[i].eof) neof++;
    checks++;
    if (sq.size() != 0 || neof != 0) begin
      failures++;
      $display("FAIL rstmid_nostat: got %0d status %0d eof want 0 0", sq.size(), neof);
    end
    oq.delete(); sq.delete();
    make_frame(60, 8'h55, g);
    send(g, 64, 1, 0, ec);
    idle(3);
    checks++;
    if (sq.size() != 1 || {sq[0].crc_ok, sq[0].len} !== {1'b1, 11'd64} || oq.size() != 60 ||
        oq[0].sof !== 1'b1 || oq[0].d !== 8'h55) begin
      failures++;
      $display("FAIL rstmid_next: got n=%0d crc=%b outs=%0d want 1 1 60", sq.size(), sq[0].crc_ok, oq.size());
    end
  endtask

  initial begin
    test_reset;
    test_good;
    test_bad_crc;
    test_short;
    test_abort;
    test_back_to_back;
    test_long;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
